// File: rtl/core_bus_arbiter.sv
`timescale 1ns/1ps
// Purpose: arbitrates single-cycle fetch and mem requests onto one downstream bus, one transaction at a time.
// Latency: downstream request one cycle after the upstream pulse; upstream response one cycle after the bus response.
// Backpressure: one pending slot per port; pulses are dropped while that port is pending or outstanding.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   fetch_request_enable, freq_*    fetch request pulse and fields
//   fetch_response_enable, fresp_*  fetch response pulse and data
//   mem_request_enable, mreq_*      mem request pulse and fields
//   mem_response_enable, mresp_*    mem response pulse and data
//   bus_request_enable, breq_*      downstream request pulse and held fields (breq_is_fetch = source)
//   bus_response_enable, bresp_data downstream response
//   mmu_exception_enable            aborts the outstanding downstream transaction
module core_bus_arbiter #(
  parameter bit MEM_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_request_enable,
  input  logic        freq_mode,
  input  logic [31:0] freq_addr,
  input  logic [31:0] freq_wdata,
  input  logic [3:0]  freq_wstrb,
  output logic        fetch_response_enable,
  output logic [31:0] fresp_data,
  input  logic        mem_request_enable,
  input  logic        mreq_mode,
  input  logic [31:0] mreq_addr,
  input  logic [31:0] mreq_wdata,
  input  logic [3:0]  mreq_wstrb,
  output logic        mem_response_enable,
  output logic [31:0] mresp_data,
  output logic        bus_request_enable,
  output logic        breq_mode,
  output logic [31:0] breq_addr,
  output logic [31:0] breq_wdata,
  output logic [3:0]  breq_wstrb,
  output logic        breq_is_fetch,
  input  logic        bus_response_enable,
  input  logic [31:0] bresp_data,
  input  logic        mmu_exception_enable
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    BUSY_FETCH = 2'd1,
    BUSY_MEM   = 2'd2
  } state_t;

  state_t state;

  logic        f_pend;
  logic        f_mode;
  logic [31:0] f_addr;
  logic [31:0] f_wdata;
  logic [3:0]  f_wstrb;

  logic        m_pend;
  logic        m_mode;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;

  // Source of the most recent grant, used to stop one port hogging the bus.
  logic        last_fetch;

  logic        f_take;
  logic        m_take;
  logic        f_cand;
  logic        m_cand;
  logic        grant_f;
  logic        grant_m;
  logic        pick_mem;

  logic        c_mode;
  logic [31:0] c_addr;
  logic [31:0] c_wdata;
  logic [3:0]  c_wstrb;

  // A pulse is accepted only when its port has neither a pending nor an outstanding request.
  assign f_take = fetch_request_enable && !f_pend && (state != BUSY_FETCH);
  assign m_take = mem_request_enable   && !m_pend && (state != BUSY_MEM);
  assign f_cand = f_pend || f_take;
  assign m_cand = m_pend || m_take;

  always_comb begin
    grant_f  = 1'b0;
    grant_m  = 1'b0;
    pick_mem = MEM_FIRST;
    if (state == IDLE) begin
      if (f_cand && m_cand) begin
        // The loser of fixed priority wins instead when it has already waited
        // through a grant that went to the priority port.
        if (MEM_FIRST && !last_fetch && f_pend) pick_mem = 1'b0;
        if (!MEM_FIRST && last_fetch && m_pend) pick_mem = 1'b1;
        grant_m = pick_mem;
        grant_f = !pick_mem;
      end else begin
        grant_f = f_cand;
        grant_m = m_cand;
      end
    end
  end

  // Granted request comes from the pending slot if one is held, else straight from the pulse.
  always_comb begin
    if (grant_f) begin
      c_mode  = f_pend ? f_mode  : freq_mode;
      c_addr  = f_pend ? f_addr  : freq_addr;
      c_wdata = f_pend ? f_wdata : freq_wdata;
      c_wstrb = f_pend ? f_wstrb : freq_wstrb;
    end else begin
      c_mode  = m_pend ? m_mode  : mreq_mode;
      c_addr  = m_pend ? m_addr  : mreq_addr;
      c_wdata = m_pend ? m_wdata : mreq_wdata;
      c_wstrb = m_pend ? m_wstrb : mreq_wstrb;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                 <= IDLE;
      f_pend                <= 1'b0;
      f_mode                <= 1'b0;
      f_addr                <= '0;
      f_wdata               <= '0;
      f_wstrb               <= '0;
      m_pend                <= 1'b0;
      m_mode                <= 1'b0;
      m_addr                <= '0;
      m_wdata               <= '0;
      m_wstrb               <= '0;
      last_fetch            <= 1'b0;
      bus_request_enable    <= 1'b0;
      breq_mode             <= 1'b0;
      breq_addr             <= '0;
      breq_wdata            <= '0;
      breq_wstrb            <= '0;
      breq_is_fetch         <= 1'b0;
      fetch_response_enable <= 1'b0;
      fresp_data            <= '0;
      mem_response_enable   <= 1'b0;
      mresp_data            <= '0;
    end else begin
      bus_request_enable    <= 1'b0;
      fetch_response_enable <= 1'b0;
      mem_response_enable   <= 1'b0;

      if (grant_f) begin
        f_pend <= 1'b0;
      end else if (f_take) begin
        f_pend  <= 1'b1;
        f_mode  <= freq_mode;
        f_addr  <= freq_addr;
        f_wdata <= freq_wdata;
        f_wstrb <= freq_wstrb;
      end

      if (grant_m) begin
        m_pend <= 1'b0;
      end else if (m_take) begin
        m_pend  <= 1'b1;
        m_mode  <= mreq_mode;
        m_addr  <= mreq_addr;
        m_wdata <= mreq_wdata;
        m_wstrb <= mreq_wstrb;
      end

      case (state)
        IDLE: begin
          if (grant_f || grant_m) begin
            bus_request_enable <= 1'b1;
            breq_is_fetch      <= grant_f;
            breq_mode          <= c_mode;
            breq_addr          <= c_addr;
            breq_wdata         <= c_wdata;
            breq_wstrb         <= c_wstrb;
            last_fetch         <= grant_f;
            state              <= grant_f ? BUSY_FETCH : BUSY_MEM;
          end
        end
        BUSY_FETCH, BUSY_MEM: begin
          // The issue cycle itself cannot end the transaction; this keeps
          // back-to-back downstream requests at least three cycles apart.
          if (!bus_request_enable) begin
            if (mmu_exception_enable) begin
              state <= IDLE;
            end else if (bus_response_enable) begin
              state <= IDLE;
              if (state == BUSY_FETCH) begin
                fetch_response_enable <= 1'b1;
                fresp_data            <= bresp_data;
              end else begin
                mem_response_enable <= 1'b1;
                mresp_data          <= bresp_data;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_bus_arbiter.sv
`timescale 1ns/1ps
module tb_core_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_request_enable, freq_mode;
  logic [31:0] freq_addr, freq_wdata;
  logic [3:0]  freq_wstrb;
  logic        fetch_response_enable;
  logic [31:0] fresp_data;
  logic        mem_request_enable, mreq_mode;
  logic [31:0] mreq_addr, mreq_wdata;
  logic [3:0]  mreq_wstrb;
  logic        mem_response_enable;
  logic [31:0] mresp_data;
  logic        bus_request_enable, breq_mode, breq_is_fetch;
  logic [31:0] breq_addr, breq_wdata;
  logic [3:0]  breq_wstrb;
  logic        bus_response_enable;
  logic [31:0] bresp_data;
  logic        mmu_exception_enable;

  core_bus_arbiter #(.MEM_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst),
    .fetch_request_enable(fetch_request_enable), .freq_mode(freq_mode),
    .freq_addr(freq_addr), .freq_wdata(freq_wdata), .freq_wstrb(freq_wstrb),
    .fetch_response_enable(fetch_response_enable), .fresp_data(fresp_data),
    .mem_request_enable(mem_request_enable), .mreq_mode(mreq_mode),
    .mreq_addr(mreq_addr), .mreq_wdata(mreq_wdata), .mreq_wstrb(mreq_wstrb),
    .mem_response_enable(mem_response_enable), .mresp_data(mresp_data),
    .bus_request_enable(bus_request_enable), .breq_mode(breq_mode),
    .breq_addr(breq_addr), .breq_wdata(breq_wdata), .breq_wstrb(breq_wstrb),
    .breq_is_fetch(breq_is_fetch),
    .bus_response_enable(bus_response_enable), .bresp_data(bresp_data),
    .mmu_exception_enable(mmu_exception_enable)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_f_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { bit is_fetch; logic [31:0] addr; } req_t;
  typedef struct { bit is_fetch; logic [31:0] data; } rsp_t;
  req_t req_q[$];
  rsp_t rsp_q[$];

  // Request side fields are derived from the address so every field is exercised.
  function automatic logic mode_of(input logic [31:0] a);
    return a[12];
  endfunction
  function automatic logic [31:0] wdata_of(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction
  function automatic logic [3:0] wstrb_of(input logic [31:0] a);
    return a[15:12];
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic exp_req(input bit f, input logic [31:0] a);
    req_t e;
    e.is_fetch = f;
    e.addr     = a;
    req_q.push_back(e);
  endtask

  // Scoreboard: every downstream request and upstream response is popped and compared.
  req_t        mon_e;
  rsp_t        mon_r;
  logic        mon_f;
  logic [31:0] mon_d;
  always @(negedge clk) begin
    if (bus_request_enable) begin
      if (req_q.size() == 0) begin
        chk("unexpected_req", 64'(bus_request_enable), 64'(0));
      end else begin
        mon_e = req_q.pop_front();
        chk("req_src",   64'(breq_is_fetch), 64'(mon_e.is_fetch));
        chk("req_addr",  64'(breq_addr),     64'(mon_e.addr));
        chk("req_mode",  64'(breq_mode),     64'(mode_of(mon_e.addr)));
        chk("req_wdata", 64'(breq_wdata),    64'(wdata_of(mon_e.addr)));
        chk("req_wstrb", 64'(breq_wstrb),    64'(wstrb_of(mon_e.addr)));
      end
    end
    if (fetch_response_enable && mem_response_enable)
      chk("resp_both", 64'(mem_response_enable), 64'(0));
    if (fetch_response_enable) last_f_cyc = cyc;
    if (fetch_response_enable || mem_response_enable) begin
      mon_f = fetch_response_enable;
      mon_d = mon_f ? fresp_data : mresp_data;
      if (rsp_q.size() == 0) begin
        chk("unexpected_resp", 64'(1'b1 & (fetch_response_enable | mem_response_enable)), 64'(0));
      end else begin
        mon_r = rsp_q.pop_front();
        chk("rsp_port", 64'(mon_f), 64'(mon_r.is_fetch));
        chk("rsp_data", 64'(mon_d), 64'(mon_r.data));
      end
    end
  end

  task automatic drive_req(input bit do_f, input logic [31:0] fa,
                           input bit do_m, input logic [31:0] ma, output int c);
    @(posedge clk); #1;
    c = cyc;
    fetch_request_enable = do_f;
    freq_addr  = fa;  freq_mode = mode_of(fa);
    freq_wdata = wdata_of(fa); freq_wstrb = wstrb_of(fa);
    mem_request_enable = do_m;
    mreq_addr  = ma;  mreq_mode = mode_of(ma);
    mreq_wdata = wdata_of(ma); mreq_wstrb = wstrb_of(ma);
    @(posedge clk); #1;
    fetch_request_enable = 1'b0;
    mem_request_enable   = 1'b0;
  endtask

  task automatic wait_req(output int c);
    int n;
    c = -1;
    n = 0;
    while (c < 0 && n < 40) begin
      @(negedge clk);
      if (bus_request_enable) c = cyc;
      n++;
    end
    if (c < 0) chk("req_timeout", 64'(bus_request_enable), 64'(1));
  endtask

  task automatic respond(input logic [31:0] exp_addr, input logic [31:0] data,
                         input bit is_fetch, input bit exc, input int dly, output int c);
    rsp_t r;
    repeat (dly + 1) @(posedge clk);
    #1;
    c = cyc;
    chk("breq_hold", 64'(breq_addr), 64'(exp_addr));
    bus_response_enable  = 1'b1;
    bresp_data           = data;
    mmu_exception_enable = exc;
    if (!exc) begin
      r.is_fetch = is_fetch;
      r.data     = data;
      rsp_q.push_back(r);
    end
    @(posedge clk); #1;
    bus_response_enable  = 1'b0;
    mmu_exception_enable = 1'b0;
    bresp_data           = '0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_breq_en"},  64'(bus_request_enable),    64'(0));
    chk({tag, "_fresp_en"}, 64'(fetch_response_enable), 64'(0));
    chk({tag, "_mresp_en"}, 64'(mem_response_enable),   64'(0));
    chk({tag, "_breq_addr"},  64'(breq_addr),  64'(0));
    chk({tag, "_breq_wdata"}, 64'(breq_wdata), 64'(0));
    chk({tag, "_breq_wstrb"}, 64'(breq_wstrb), 64'(0));
    chk({tag, "_breq_mode"},  64'(breq_mode),  64'(0));
    chk({tag, "_breq_src"},   64'(breq_is_fetch), 64'(0));
    chk({tag, "_fresp_data"}, 64'(fresp_data), 64'(0));
    chk({tag, "_mresp_data"}, 64'(mresp_data), 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got still running want finished");
    $fatal(1);
  end

  initial begin
    int c0, a, b, d, cr;
    rst = 1'b1;
    fetch_request_enable = 0; freq_mode = 0; freq_addr = 0; freq_wdata = 0; freq_wstrb = 0;
    mem_request_enable = 0;   mreq_mode = 0; mreq_addr = 0; mreq_wdata = 0; mreq_wstrb = 0;
    bus_response_enable = 0; bresp_data = 0; mmu_exception_enable = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Single fetch with exact timing.
    exp_req(1'b1, 32'h1000);
    drive_req(1'b1, 32'h1000, 1'b0, 32'h0, c0);
    wait_req(a);
    chk("fetch_issue_lat", 64'(a - c0), 64'd1);
    respond(32'h1000, 32'hDEAD_BEEF, 1'b1, 1'b0, 1, cr);
    chk("fetch_bresp_cyc", 64'(cr - c0), 64'd3);
    @(negedge clk); #1;
    chk("fetch_resp_cyc", 64'(last_f_cyc - c0), 64'd4);

    // Response and exception while idle are ignored.
    @(posedge clk); #1;
    bus_response_enable = 1'b1; bresp_data = 32'h1234_5678;
    @(posedge clk); #1;
    bus_response_enable = 1'b0; mmu_exception_enable = 1'b1;
    @(posedge clk); #1;
    mmu_exception_enable = 1'b0; bresp_data = '0;
    repeat (3) @(posedge clk);

    // Simultaneous requests: mem first, responses routed to their own port.
    exp_req(1'b0, 32'h8000);
    exp_req(1'b1, 32'h2000);
    drive_req(1'b1, 32'h2000, 1'b1, 32'h8000, c0);
    wait_req(a);
    respond(32'h8000, 32'h8888_0001, 1'b0, 1'b0, 0, cr);
    wait_req(b);
    chk("b2b_spacing", 64'(b - a), 64'd3);
    respond(32'h2000, 32'h2222_0002, 1'b1, 1'b0, 2, cr);

    // Exception together with a response aborts mem; pending fetch follows.
    exp_req(1'b0, 32'h3000);
    exp_req(1'b1, 32'h4000);
    drive_req(1'b0, 32'h0, 1'b1, 32'h3000, c0);
    wait_req(a);
    drive_req(1'b1, 32'h4000, 1'b0, 32'h0, c0);
    respond(32'h3000, 32'hBAD0_BAD0, 1'b0, 1'b1, 0, cr);
    wait_req(b);
    chk("exc_next_issue", 64'(b - cr), 64'd2);
    respond(32'h4000, 32'h4444_0004, 1'b1, 1'b0, 0, cr);

    // Duplicate fetch while outstanding is dropped.
    exp_req(1'b1, 32'h5000);
    drive_req(1'b1, 32'h5000, 1'b0, 32'h0, c0);
    wait_req(a);
    drive_req(1'b1, 32'h5004, 1'b0, 32'h0, c0);
    respond(32'h5000, 32'h5555_0005, 1'b1, 1'b0, 1, cr);
    repeat (8) @(posedge clk);

    // Fairness: mem pulsing every cycle cannot keep a pending fetch out.
    exp_req(1'b0, 32'h6000);
    exp_req(1'b1, 32'h7000);
    exp_req(1'b0, 32'h6000);
    mreq_addr = 32'h6000; mreq_mode = mode_of(32'h6000);
    mreq_wdata = wdata_of(32'h6000); mreq_wstrb = wstrb_of(32'h6000);
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          @(posedge clk); #1;
          mem_request_enable = 1'b1;
        end
        @(posedge clk); #1;
        mem_request_enable = 1'b0;
      end
      begin
        @(posedge clk); @(posedge clk); #1;
        fetch_request_enable = 1'b1;
        freq_addr = 32'h7000; freq_mode = mode_of(32'h7000);
        freq_wdata = wdata_of(32'h7000); freq_wstrb = wstrb_of(32'h7000);
        @(posedge clk); #1;
        fetch_request_enable = 1'b0;
      end
      begin
        int fa, fb, fc, fr;
        wait_req(fa);
        respond(32'h6000, 32'h6666_0006, 1'b0, 1'b0, 0, fr);
        wait_req(fb);
        chk("fair_spacing", 64'(fb - fa), 64'd3);
        respond(32'h7000, 32'h7777_0007, 1'b1, 1'b0, 0, fr);
        wait_req(fc);
        respond(32'h6000, 32'h6666_0008, 1'b0, 1'b0, 0, fr);
      end
    join
    repeat (4) @(posedge clk);

    // Reset while busy with mem and fetch pending discards everything.
    exp_req(1'b0, 32'h9000);
    drive_req(1'b0, 32'h0, 1'b1, 32'h9000, c0);
    wait_req(a);
    drive_req(1'b1, 32'hA000, 1'b0, 32'h0, c0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_zero("mid_rst");
    @(posedge clk); #1;
    bus_response_enable = 1'b1; bresp_data = 32'h9999_0009;
    @(posedge clk); #1;
    bus_response_enable = 1'b0; bresp_data = '0;
    repeat (6) @(posedge clk);

    // First grant after reset follows mem-first priority.
    exp_req(1'b0, 32'hB000);
    exp_req(1'b1, 32'hC000);
    drive_req(1'b1, 32'hC000, 1'b1, 32'hB000, c0);
    wait_req(a);
    respond(32'hB000, 32'hBBBB_000B, 1'b0, 1'b0, 1, cr);
    wait_req(d);
    respond(32'hC000, 32'hCCCC_000C, 1'b1, 1'b0, 0, cr);

    repeat (4) @(posedge clk);
    chk("req_q_left", 64'(req_q.size()), 64'(0));
    chk("rsp_q_left", 64'(rsp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/core_bus_arbiter.md
CORE_BUS_ARBITER -- requirements
Module: core_bus_arbiter

Interface
REQ-001 The block SHALL have one clock, clk, and a synchronous, active-high reset, rst, sampled on the rising edge of clk.
REQ-002 The block SHALL have parameter MEM_FIRST, default 1: on simultaneous fetch and mem requests, 1 grants mem first and 0 grants fetch first.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- fetch_request_enable  in  1  single-cycle fetch request pulse
- freq_mode, freq_addr, freq_wdata, freq_wstrb  in  1/32/32/4  fetch request fields
- fetch_response_enable  out  1  fetch response pulse
- fresp_data  out  32  fetch response data
- mem_request_enable  in  1  single-cycle mem request pulse
- mreq_mode, mreq_addr, mreq_wdata, mreq_wstrb  in  1/32/32/4  mem request fields
- mem_response_enable  out  1  mem response pulse
- mresp_data  out  32  mem response data
- bus_request_enable  out  1  downstream request pulse
- breq_mode, breq_addr, breq_wdata, breq_wstrb  out  1/32/32/4  downstream request fields
- breq_is_fetch  out  1  source of the current downstream request (1 = fetch)
- bus_response_enable  in  1  downstream response pulse
- bresp_data  in  32  downstream response data
- mmu_exception_enable  in  1  aborts the outstanding downstream transaction

Function
REQ-004 Each upstream port SHALL have a one-entry pending register; a request pulse SHALL capture mode/addr/wdata/wstrb into it and set the port's pending flag.
REQ-005 A request pulse arriving while the same port's pending flag is set, or while that port's transaction is outstanding, SHALL be ignored.
REQ-006 The FSM SHALL have states IDLE, BUSY_FETCH and BUSY_MEM.
REQ-007 In IDLE with a request pending (or a request pulse arriving in the same cycle), the block SHALL grant per MEM_FIRST, drive bus_request_enable high for exactly one cycle, and move to BUSY_<source>.
REQ-008 The downstream request SHALL issue one cycle after the upstream pulse at the earliest.
REQ-009 In IDLE, a pulse and an already-pending request from the other port in the same cycle SHALL both be arbitrated per MEM_FIRST.
REQ-010 The breq_* fields and breq_is_fetch SHALL be registered and SHALL hold stable from the issue cycle until the transaction ends.
REQ-011 The granted port's pending flag SHALL clear in the issue cycle.
REQ-012 In BUSY_x, bus_response_enable SHALL end the transaction: the next cycle pulses x_response_enable for one cycle with registered data equal to bresp_data, and the FSM returns to IDLE.
REQ-013 In BUSY_x, mmu_exception_enable SHALL end the transaction with no upstream response pulse and return to IDLE.
REQ-014 If mmu_exception_enable and bus_response_enable are asserted in the same cycle, the exception SHALL win and no response pulse SHALL be produced.
REQ-015 Response and exception inputs asserted in IDLE SHALL be ignored.
REQ-016 A new grant SHALL be allowed in the cycle after return to IDLE, giving a minimum 3 cycles between back-to-back downstream requests.
REQ-017 When the granted port's next request is already pending, the other port's pending request SHALL win the next grant, so that neither port can starve the other.
REQ-018 The block SHALL perform no address or data modification; all widths pass through unchanged.

Reset
REQ-019 While rst is high: state SHALL be IDLE; both pending flags SHALL be 0; bus_request_enable, fetch_response_enable and mem_response_enable SHALL be 0; breq_*, breq_is_fetch, fresp_data and mresp_data SHALL be 0.
REQ-020 Reset asserted mid-transaction SHALL discard all pending and outstanding transactions, with no response pulse afterward.
REQ-021 The first grant after reset SHALL follow MEM_FIRST.

Verification
REQ-022 Single fetch: fetch pulse, addr 0x1000 at cycle 0 -> bus_request_enable at cycle 1 with breq_addr 0x1000 and breq_is_fetch=1; bresp 0xDEADBEEF at cycle 3 -> fetch_response_enable at cycle 4 with fresp_data 0xDEADBEEF.
REQ-023 Simultaneous requests, MEM_FIRST=1: fetch 0x2000 and mem 0x8000 pulsed in the same cycle -> mem issued first; after the mem response, fetch 0x2000 is issued; each response is routed only to its own port.
REQ-024 Exception abort: mem request issued, then mmu_exception_enable together with bus_response_enable -> no mem_response_enable pulse; FSM in IDLE; the next pending fetch is issued the following cycle.
REQ-025 Duplicate request: second fetch pulse while fetch is outstanding -> ignored; exactly one downstream request and one response.
REQ-026 Reset mid-operation: rst while BUSY_MEM with fetch pending -> all outputs 0 next cycle; a later bus_response_enable produces no response pulse.
REQ-027 Fairness: mem pulses every cycle while a fetch is pending -> fetch is granted no later than the second grant.
